// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared types and helpers for the tx_core control sequencer.
//   tx_seq_entry_t : packed table entry {dwell, phase_inc, sel} at the default dwell width
//   tx_seq_state_t : sequencer states
//   sel_to_chan()  : maps a DAC source select to the DDS channel whose increment it loads
package tx_seq_pkg;

    localparam int TX_SEQ_DEPTH   = 16;
    localparam int TX_SEQ_DWELL_W = 24;

    typedef struct packed {
        logic [TX_SEQ_DWELL_W-1:0] dwell;
        logic [15:0]               phase_inc;
        logic [2:0]                sel;
    } tx_seq_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_TRIG = 2'd2
    } tx_seq_state_t;

    // Sources 1/4, 2/5 and 3/6 share DDS channels 1, 2 and 3; 0 and 7 use no DDS.
    function automatic logic [1:0] sel_to_chan(input logic [2:0] sel);
        return (sel == 3'd0 || sel == 3'd7) ? 2'd0 :
               (sel > 3'd3)                 ? 2'(sel - 3'd3) : sel[1:0];
    endfunction

endpackage

// File: rtl/tx_seq_table.sv
// tx_seq_table: DEPTH x W entry register file, one synchronous write port,
// one combinational read port. Contents are not reset.
//   clock   in  system clock
//   wr_en   in  write strobe
//   wr_addr in  write address
//   wr_data in  write data
//   rd_addr in  read address
//   rd_data out read data (old contents when read and write hit the same address)
module tx_seq_table #(
    parameter int DEPTH  = 16,
    parameter int W      = 43,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_seq_ctrl.sv
// tx_seq_ctrl: steps through a programmable table of {sel, phase_inc, dwell} entries and
// drives the tx_core control inputs, holding each entry for max(dwell,1) cycles.
// Optional feature macro: TX_SEQ_EXT_TRIG_EN (adds ext_trig port and WAIT_TRIG state;
// after each dwell the sequencer waits for an ext_trig pulse before advancing).
//   clock          in  system clock
//   resetn         in  synchronous active-low reset
//   cfg_wr_en      in  table write strobe
//   cfg_wr_addr    in  table write address
//   cfg_wr_data    in  {dwell, phase_inc, sel}
//   num_entries    in  active entry count, sampled on accepted start, clamped to DEPTH
//   loop_en        in  wrap to entry 0 after the last entry
//   start          in  start level, acted on in IDLE only
//   stop           in  abort; outputs hold
//   ext_trig       in  advance trigger (TX_SEQ_EXT_TRIG_EN only)
//   output_select  out tx_core source select
//   dds_phase_inc1..3 out tx_core DDS phase increments
//   update         out pulse in the cycle a new entry appears
//   busy           out not IDLE
//   done           out pulse on single-pass completion
//   cur_index      out index of the applied entry
module tx_seq_ctrl
    import tx_seq_pkg::*;
#(
    parameter int DEPTH   = TX_SEQ_DEPTH,
    parameter int DWELL_W = TX_SEQ_DWELL_W,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ENTRY_W = 19 + DWELL_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_wr_en,
    input  logic [ADDR_W-1:0]  cfg_wr_addr,
    input  logic [ENTRY_W-1:0] cfg_wr_data,
    input  logic [ADDR_W:0]    num_entries,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
`ifdef TX_SEQ_EXT_TRIG_EN
    input  logic               ext_trig,
`endif
    output logic [2:0]         output_select,
    output logic [15:0]        dds_phase_inc1,
    output logic [15:0]        dds_phase_inc2,
    output logic [15:0]        dds_phase_inc3,
    output logic               update,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  cur_index
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_WAIT = WAIT_TRIG;

    logic [1:0]         state, state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [ADDR_W-1:0]  last_idx, rd_addr;
    logic [ADDR_W:0]    n_clamp;
    logic [ENTRY_W-1:0] rd_data;
    logic [2:0]         rd_sel;
    logic [15:0]        rd_inc;
    logic [DWELL_W-1:0] rd_dwell;
    logic [1:0]         chan;
    logic               start_ok, last_hit, expire, to_wait, apply, finish;

    tx_seq_table #(.DEPTH(DEPTH), .W(ENTRY_W)) u_table (
        .clock   (clock),
        .wr_en   (cfg_wr_en),
        .wr_addr (cfg_wr_addr),
        .wr_data (cfg_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_sel   = rd_data[2:0];
    assign rd_inc   = rd_data[18:3];
    assign rd_dwell = rd_data[ENTRY_W-1:19];

    always_comb begin
        n_clamp  = (num_entries > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_entries;
        start_ok = state == S_IDLE && start && !stop && n_clamp != '0;
        last_hit = cur_index == last_idx;
`ifdef TX_SEQ_EXT_TRIG_EN
        expire   = state == S_WAIT && ext_trig && !stop;
        to_wait  = state == S_RUN && cnt == '0 && !stop;
`else
        expire   = state == S_RUN && cnt == '0 && !stop;
        to_wait  = 1'b0;
`endif
        // expire is the advance/wrap/finish decision point for the current entry
        apply     = start_ok || (expire && (!last_hit || loop_en));
        finish    = expire && last_hit && !loop_en;
        rd_addr   = (start_ok || last_hit) ? '0 : cur_index + 1'b1;
        chan      = sel_to_chan(rd_sel);
        state_nxt = ((stop && state != S_IDLE) || finish) ? S_IDLE :
                    apply   ? S_RUN  :
                    to_wait ? S_WAIT : state;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            last_idx       <= '0;
            output_select  <= 3'd1;
            dds_phase_inc1 <= '0;
            dds_phase_inc2 <= '0;
            dds_phase_inc3 <= '0;
            update         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cur_index      <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= state_nxt != S_IDLE;
            update <= apply;
            done   <= finish;
            if (start_ok) last_idx <= ADDR_W'(n_clamp - 1'b1);
            if (apply) begin
                output_select <= rd_sel;
                cur_index     <= rd_addr;
                // loading dwell-1 makes the entry visible for exactly max(dwell,1) cycles
                cnt           <= (rd_dwell == '0) ? '0 : rd_dwell - 1'b1;
            end else if (state == S_RUN && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (apply && chan == 2'd1) dds_phase_inc1 <= rd_inc;
            if (apply && chan == 2'd2) dds_phase_inc2 <= rd_inc;
            if (apply && chan == 2'd3) dds_phase_inc3 <= rd_inc;
        end
    end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// tb_tx_seq_ctrl: self-checking bench for tx_seq_ctrl; expected applies are queued
// from a table model when stimulus is driven and compared on every update pulse.
module tb_tx_seq_ctrl;
    import tx_seq_pkg::*;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] i1;
        logic [15:0] i2;
        logic [15:0] i3;
        logic [3:0]  idx;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_addr = '0;
    logic [42:0] cfg_wr_data = '0;
    logic [4:0]  num_entries = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ext_trig = 1'b0;
    logic [2:0]  output_select;
    logic [15:0] dds_phase_inc1, dds_phase_inc2, dds_phase_inc3;
    logic        update, busy, done;
    logic [3:0]  cur_index;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ts[$];
    exp_t q[$];
    exp_t got, want;
    tx_seq_entry_t tbl [16];
    logic [2:0]  m_sel;
    logic [15:0] m_inc1, m_inc2, m_inc3;

    tx_seq_ctrl dut (
        .clock          (clock),
        .resetn         (resetn),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .num_entries    (num_entries),
        .loop_en        (loop_en),
        .start          (start),
        .stop           (stop),
`ifdef TX_SEQ_EXT_TRIG_EN
        .ext_trig       (ext_trig),
`endif
        .output_select  (output_select),
        .dds_phase_inc1 (dds_phase_inc1),
        .dds_phase_inc2 (dds_phase_inc2),
        .dds_phase_inc3 (dds_phase_inc3),
        .update         (update),
        .busy           (busy),
        .done           (done),
        .cur_index      (cur_index)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resetn && update) begin
            checks++;
            ts.push_back(cyc);
            got = {output_select, dds_phase_inc1, dds_phase_inc2, dds_phase_inc3, cur_index};
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_update: got sel=%0d idx=%0d, required no update", output_select, cur_index);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL sb_apply: got sel=%0d inc=%h/%h/%h idx=%0d, required sel=%0d inc=%h/%h/%h idx=%0d",
                             got.sel, got.i1, got.i2, got.i3, got.idx, want.sel, want.i1, want.i2, want.i3, want.idx);
                end
            end
        end
        if (resetn && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        ext_trig = 1'b0;
        tick(3);
        resetn = 1'b1;
        m_sel = 3'd1;
        m_inc1 = '0;
        m_inc2 = '0;
        m_inc3 = '0;
        q.delete();
        ts.delete();
    endtask

    task automatic write_entry(input int a, input logic [2:0] sel, input logic [15:0] inc, input logic [23:0] dwell);
        tx_seq_entry_t e;
        e.sel = sel;
        e.phase_inc = inc;
        e.dwell = dwell;
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 4'(a);
        cfg_wr_data = e;
        tick(1);
        cfg_wr_en = 1'b0;
        tbl[a] = e;
    endtask

    task automatic push_apply(input int k);
        tx_seq_entry_t e;
        exp_t x;
        e = tbl[k];
        m_sel = e.sel;
        case (e.sel)
            3'd1, 3'd4: m_inc1 = e.phase_inc;
            3'd2, 3'd5: m_inc2 = e.phase_inc;
            3'd3, 3'd6: m_inc3 = e.phase_inc;
            default: ;
        endcase
        x.sel = m_sel;
        x.i1 = m_inc1;
        x.i2 = m_inc2;
        x.i3 = m_inc3;
        x.idx = 4'(k);
        q.push_back(x);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (output_select !== 3'd1) begin failures++; $display("FAIL reset_sel: got %0d, required 1", output_select); end
        checks++;
        if ({dds_phase_inc1, dds_phase_inc2, dds_phase_inc3} !== 48'h0) begin
            failures++; $display("FAIL reset_incs: got %h/%h/%h, required 0", dds_phase_inc1, dds_phase_inc2, dds_phase_inc3);
        end
        checks++;
        if ({busy, update, done} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got busy/update/done=%b, required 000", {busy, update, done});
        end
        checks++;
        if (cur_index !== 4'd0) begin failures++; $display("FAIL reset_index: got %0d, required 0", cur_index); end
        tick(100);
        checks++;
        if (output_select !== 3'd1 || busy !== 1'b0 || dds_phase_inc1 !== 16'h0) begin
            failures++; $display("FAIL idle_hold: got sel=%0d busy=%b inc1=%h, required 1/0/0000", output_select, busy, dds_phase_inc1);
        end
        checks++;
        if (ts.size() != 0) begin failures++; $display("FAIL idle_no_update: got %0d updates, required 0", ts.size()); end
    endtask

    task automatic test_single_pass();
        int d0, g;
        reset_dut();
        write_entry(0, 3'd4, 16'h1000, 24'd3);
        write_entry(1, 3'd5, 16'h2000, 24'd0);
        num_entries = 5'd2;
        loop_en = 1'b0;
        push_apply(0);
        push_apply(1);
        d0 = done_cnt;
        start_pulse();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b, required 1", busy); end
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick(1);
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt - d0); end
        checks++;
        if (ts.size() != 2) begin failures++; $display("FAIL single_updates: got %0d, required 2", ts.size()); end
        g = (ts.size() >= 2) ? ts[1] - ts[0] : -1;
        checks++;
        if (g != 3) begin failures++; $display("FAIL single_dwell3: got %0d cycles, required 3", g); end
        g = (ts.size() >= 2) ? done_cyc - ts[1] : -1;
        checks++;
        if (g != 1) begin failures++; $display("FAIL single_dwell0: got %0d cycles, required 1", g); end
        tick(3);
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            failures++; $display("FAIL single_end: got done=%0d busy=%b, required 1/0", done_cnt - d0, busy);
        end
        checks++;
        if (output_select !== 3'd5 || dds_phase_inc1 !== 16'h1000 || dds_phase_inc2 !== 16'h2000) begin
            failures++; $display("FAIL single_hold: got sel=%0d inc1=%h inc2=%h, required 5/1000/2000", output_select, dds_phase_inc1, dds_phase_inc2);
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL single_pending: got %0d, required 0", q.size()); end
    endtask

    task automatic test_loop_stop();
        int d0, g;
        reset_dut();
        num_entries = 5'd2;
        loop_en = 1'b1;
        for (int i = 0; i < 5; i++) push_apply(i % 2);
        d0 = done_cnt;
        start_pulse();
        tick(9);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL loop_stop_busy: got %b, required 0", busy); end
        checks++;
        if (output_select !== 3'd4 || cur_index !== 4'd0 || dds_phase_inc1 !== 16'h1000 || dds_phase_inc2 !== 16'h2000) begin
            failures++; $display("FAIL loop_stop_hold: got sel=%0d idx=%0d inc1=%h inc2=%h, required 4/0/1000/2000",
                                 output_select, cur_index, dds_phase_inc1, dds_phase_inc2);
        end
        tick(10);
        checks++;
        if (ts.size() != 5 || q.size() != 0) begin
            failures++; $display("FAIL loop_count: got %0d updates %0d pending, required 5/0", ts.size(), q.size());
        end
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL loop_no_done: got %0d pulses, required 0", done_cnt - d0); end
        g = (ts.size() >= 5) ? ts[4] - ts[2] : -1;
        checks++;
        if (g != 4) begin failures++; $display("FAIL loop_period: got %0d, required 4", g); end
    endtask

    task automatic test_zero_and_clamp();
        int g;
        reset_dut();
        num_entries = 5'd0;
        loop_en = 1'b1;
        start = 1'b1;
        tick(5);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ts.size() != 0) begin
            failures++; $display("FAIL zero_entries: got busy=%b updates=%0d, required 0/0", busy, ts.size());
        end
        for (int k = 0; k < 16; k++) write_entry(k, 3'(k), 16'(k * 16'h0101), 24'(k % 2));
        num_entries = 5'd31;
        for (int i = 0; i < 18; i++) push_apply(i % 16);
        start_pulse();
        tick(17);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        checks++;
        if (ts.size() != 18 || q.size() != 0) begin
            failures++; $display("FAIL clamp_count: got %0d updates %0d pending, required 18/0", ts.size(), q.size());
        end
        g = (ts.size() >= 18) ? ts[17] - ts[0] : -1;
        checks++;
        if (g != 17) begin failures++; $display("FAIL clamp_no_gap: got %0d, required 17", g); end
        checks++;
        if (cur_index !== 4'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL clamp_end: got idx=%0d busy=%b, required 1/0", cur_index, busy);
        end
    endtask

    task automatic test_read_before_write();
        tx_seq_entry_t e;
        reset_dut();
        write_entry(0, 3'd4, 16'h1000, 24'd3);
        write_entry(1, 3'd5, 16'h2000, 24'd1);
        num_entries = 5'd2;
        loop_en = 1'b1;
        push_apply(0);
        push_apply(1);
        e.sel = 3'd6;
        e.phase_inc = 16'h3000;
        e.dwell = 24'd1;
        tbl[1] = e;
        push_apply(0);
        push_apply(1);
        start_pulse();
        tick(2);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 4'd1;
        cfg_wr_data = e;
        tick(1);
        cfg_wr_en = 1'b0;
        tick(4);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        checks++;
        if (ts.size() != 4 || q.size() != 0) begin
            failures++; $display("FAIL rbw_count: got %0d updates %0d pending, required 4/0", ts.size(), q.size());
        end
        checks++;
        if (output_select !== 3'd6 || dds_phase_inc3 !== 16'h3000 || dds_phase_inc2 !== 16'h2000) begin
            failures++; $display("FAIL rbw_new: got sel=%0d inc2=%h inc3=%h, required 6/2000/3000", output_select, dds_phase_inc2, dds_phase_inc3);
        end
    endtask

`ifdef TX_SEQ_EXT_TRIG_EN
    task automatic test_ext_trig();
        int d0, cx;
        reset_dut();
        write_entry(0, 3'd1, 16'h0111, 24'd2);
        write_entry(1, 3'd2, 16'h0222, 24'd2);
        num_entries = 5'd2;
        loop_en = 1'b0;
        push_apply(0);
        push_apply(1);
        d0 = done_cnt;
        start_pulse();
        tick(50);
        checks++;
        if (ts.size() != 1 || busy !== 1'b1 || cur_index !== 4'd0) begin
            failures++; $display("FAIL trig_hold: got updates=%0d busy=%b idx=%0d, required 1/1/0", ts.size(), busy, cur_index);
        end
        ext_trig = 1'b1;
        tick(1);
        ext_trig = 1'b0;
        cx = cyc;
        tick(1);
        checks++;
        if (ts.size() != 2 || (ts.size() == 2 && ts[1] != cx)) begin
            failures++; $display("FAIL trig_advance: got updates=%0d, required 2 on the trigger edge", ts.size());
        end
        tick(3);
        ext_trig = 1'b1;
        tick(1);
        ext_trig = 1'b0;
        tick(2);
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            failures++; $display("FAIL trig_finish: got done=%0d busy=%b, required 1/0", done_cnt - d0, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef TX_SEQ_EXT_TRIG_EN
        test_ext_trig();
`else
        test_single_pass();
        test_loop_stop();
        test_zero_and_clamp();
        test_read_before_write();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
